stage_1_join: RTL
=================

STAGE_1_JOIN -- requirements
Module: stage_1_join

Interface
REQ-001 SHALL have parameter FLT_DATA_WIDTH, default 32, the float operand width.
REQ-002 SHALL have parameter CORDIC_DATA_WIDTH, default 22, the fixed-point CORDIC operand width.
REQ-003 SHALL have parameter NUM_CH, default 2, the lane count (1..16).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, the WAIT watchdog limit; 0 disables it.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port clk_en, input, 1, the global enable qualifying every state update.
REQ-008 SHALL have port start, input, 1, the request to launch all lanes.
REQ-009 SHALL have port lane_start, output, 1, the registered start pulse broadcast to lanes.
REQ-010 SHALL have port lane_done, input, NUM_CH, the per-lane result strobes.
REQ-011 SHALL have port lane_busy, input, NUM_CH, the per-lane working flags.
REQ-012 SHALL have ports lane_half and lane_square, input, NUM_CH*FLT_DATA_WIDTH each; lane i at [i*W +: W].
REQ-013 SHALL have port lane_cordic, input, NUM_CH*CORDIC_DATA_WIDTH, packed the same way.
REQ-014 SHALL have ports out_half and out_square, output, NUM_CH*FLT_DATA_WIDTH each, the captured results.
REQ-015 SHALL have port out_cordic, output, NUM_CH*CORDIC_DATA_WIDTH, the captured CORDIC operands.
REQ-016 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-017 SHALL have ports done, working, start_drop and timeout, output, 1 each, plus timeout_mask, output, NUM_CH.

Function
REQ-018 SHALL implement states IDLE, WAIT and DONE; any other encoding SHALL return to IDLE.
REQ-019 In IDLE, start&&clk_en SHALL: clear all captured flags, clear the watchdog, pulse lane_start on the next cycle, and go to WAIT.
REQ-020 In WAIT, on a clk_en cycle, each lane with lane_done=1 and captured=0 SHALL latch its half/square/cordic into its out_* slice and set captured.
REQ-021 lane_done on an already-captured lane SHALL be ignored; its out_* slice SHALL NOT change.
REQ-022 Lanes SHALL complete in any order and on any cycles; simultaneous completion of all lanes in one cycle SHALL be legal.
REQ-023 The state SHALL go WAIT->DONE on the edge where the last uncaptured lane is captured.
REQ-024 done SHALL pulse high for exactly one cycle on entry to DONE.
REQ-025 out_valid SHALL be 1 exactly while in DONE.
REQ-026 out_valid&&out_ready&&clk_en SHALL move DONE->IDLE; out_* SHALL hold their values until the next capture.
REQ-027 Watchdog: in WAIT, a counter SHALL increment per clk_en cycle; with TIMEOUT_CYCLES>0, at count==TIMEOUT_CYCLES-1 without full capture, the block SHALL pulse timeout for 1 cycle, load timeout_mask=~captured, and go to IDLE.
REQ-028 If full capture and watchdog expiry coincide, completion SHALL win (DONE, no timeout).
REQ-029 start while not IDLE SHALL be ignored and SHALL produce a 1-cycle start_drop pulse.
REQ-030 clk_en=0 SHALL freeze state, counter, flags and out_*; pulses (done, lane_start, timeout, start_drop) SHALL deassert.
REQ-031 working SHALL be the registered OR of lane_busy, independent of clk_en.
REQ-032 Latency: start at cycle 0 -> lane_start at cycle 1; last lane_done at cycle k -> done/out_valid at cycle k+1.
REQ-033 timeout_mask SHALL hold until the next timeout or reset.

Reset
REQ-034 rst SHALL force IDLE asynchronously and clear all outputs, out_* buses, captured flags and the counter to 0, including mid-WAIT or mid-DONE.

Structure
REQ-035 The state encodings (IDLE 2'b00, WAIT 2'b01, DONE 2'b11) and default widths SHALL live in a shared package.
REQ-036 A per-lane sub-module stage_1_lane_capture (captured flag plus result registers) SHALL be instantiated NUM_CH times via generate.
REQ-037 The watchdog counter width SHALL be clog2(TIMEOUT_CYCLES+1), minimum 1.

Verification
REQ-038 Bench SHALL cover: NUM_CH=2, start, both lane_done on cycle 5, halves 0x3F000000/0x3E800000 -> done at cycle 6, out_half matches, out_valid held until out_ready.
REQ-039 Bench SHALL cover: NUM_CH=4, lanes done at cycles 3, 9, 4, 7, lane 0 re-strobed at cycle 8 with new data -> done at cycle 10, lane 0 holds its cycle-3 data.
REQ-040 Bench SHALL cover: TIMEOUT_CYCLES=8, lane 1 never done -> timeout pulse after 8 WAIT cycles, timeout_mask=2'b10, state IDLE, no done.
REQ-041 Bench SHALL cover: start asserted in WAIT and DONE -> start_drop pulses, no lane_start.
REQ-042 Bench SHALL cover: clk_en low for 3 cycles mid-WAIT while lane_done=1 -> no capture, counter frozen; capture once clk_en returns.
REQ-043 Bench SHALL cover: rst pulsed mid-WAIT and in DONE -> immediate IDLE, all outputs 0, next start runs normally.

Source files
------------

// File: rtl/stage_1_join_pkg.sv
// stage_1_join_pkg: shared state encodings, default widths and watchdog width helper
package stage_1_join_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b11} state_e;
  localparam int DEF_FLT_W = 32;
  localparam int DEF_CORDIC_W = 22;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_TIMEOUT = 64;
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/stage_1_lane_capture.sv
// stage_1_lane_capture: one lane's captured flag and first-strobe result registers
module stage_1_lane_capture
  import stage_1_join_pkg::*;
#(
  parameter int FW = DEF_FLT_W,
  parameter int CW = DEF_CORDIC_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          cap_i,
  input  logic [FW-1:0] half_i,
  input  logic [FW-1:0] square_i,
  input  logic [CW-1:0] cordic_i,
  output logic          captured_o,
  output logic          take_o,
  output logic [FW-1:0] half_o,
  output logic [FW-1:0] square_o,
  output logic [CW-1:0] cordic_o
);
  logic          captured_q, captured_d;
  logic [FW-1:0] half_q, half_d, square_q, square_d;
  logic [CW-1:0] cordic_q, cordic_d;
  // only the first strobe after a launch is taken; later ones leave the slice untouched
  assign take_o = cap_i & ~captured_q;
  always_comb begin
    captured_d = clr_i ? 1'b0 : (captured_q | take_o);
    half_d     = take_o ? half_i : half_q;
    square_d   = take_o ? square_i : square_q;
    cordic_d   = take_o ? cordic_i : cordic_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      captured_q <= 1'b0;
      half_q     <= '0;
      square_q   <= '0;
      cordic_q   <= '0;
    end else begin
      captured_q <= captured_d;
      half_q     <= half_d;
      square_q   <= square_d;
      cordic_q   <= cordic_d;
    end
  end
  assign captured_o = captured_q;
  assign half_o     = half_q;
  assign square_o   = square_q;
  assign cordic_o   = cordic_q;
endmodule

// File: rtl/stage_1_join.sv
// stage_1_join: launches all lanes, joins their results in any order, with watchdog and handshake
module stage_1_join
  import stage_1_join_pkg::*;
#(
  parameter int FLT_DATA_WIDTH    = DEF_FLT_W,
  parameter int CORDIC_DATA_WIDTH = DEF_CORDIC_W,
  parameter int NUM_CH            = DEF_NUM_CH,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clk_en,
  input  logic                                start,
  output logic                                lane_start,
  input  logic [NUM_CH-1:0]                   lane_done,
  input  logic [NUM_CH-1:0]                   lane_busy,
  input  logic [NUM_CH*FLT_DATA_WIDTH-1:0]    lane_half,
  input  logic [NUM_CH*FLT_DATA_WIDTH-1:0]    lane_square,
  input  logic [NUM_CH*CORDIC_DATA_WIDTH-1:0] lane_cordic,
  output logic [NUM_CH*FLT_DATA_WIDTH-1:0]    out_half,
  output logic [NUM_CH*FLT_DATA_WIDTH-1:0]    out_square,
  output logic [NUM_CH*CORDIC_DATA_WIDTH-1:0] out_cordic,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                done,
  output logic                                working,
  output logic                                start_drop,
  output logic                                timeout,
  output logic [NUM_CH-1:0]                   timeout_mask
);
  localparam int FW = FLT_DATA_WIDTH;
  localparam int CW = CORDIC_DATA_WIDTH;
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] mask_q, mask_d, captured, take, cap;
  logic              lane_start_q, lane_start_d, done_q, done_d;
  logic              drop_q, drop_d, timeout_q, timeout_d, working_q;
  logic              fire, all_cap, expire;
  assign fire    = start & clk_en & (state_q == IDLE);
  assign cap     = {NUM_CH{clk_en & (state_q == WAIT)}} & lane_done;
  assign all_cap = &(captured | take);
  assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    stage_1_lane_capture #(.FW(FW), .CW(CW)) u_cap (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (fire),
      .cap_i      (cap[i]),
      .half_i     (lane_half[i*FW +: FW]),
      .square_i   (lane_square[i*FW +: FW]),
      .cordic_i   (lane_cordic[i*CW +: CW]),
      .captured_o (captured[i]),
      .take_o     (take[i]),
      .half_o     (out_half[i*FW +: FW]),
      .square_o   (out_square[i*FW +: FW]),
      .cordic_o   (out_cordic[i*CW +: CW])
    );
  end
  // completion is tested before expiry so a coinciding last capture wins
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    lane_start_d = 1'b0;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    drop_d       = start & clk_en & (state_q != IDLE);
    if (clk_en) begin
      case (state_q)
        IDLE: if (start) begin
          state_d      = WAIT;
          cnt_d        = '0;
          lane_start_d = 1'b1;
        end
        WAIT: begin
          cnt_d = cnt_q + 1'b1;
          if (all_cap) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (expire) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            mask_d    = ~(captured | take);
          end
        end
        DONE: state_d = out_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      lane_start_q <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
      timeout_q    <= 1'b0;
      working_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      lane_start_q <= lane_start_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
      timeout_q    <= timeout_d;
      working_q    <= |lane_busy;
    end
  end
  assign lane_start   = lane_start_q;
  assign done         = done_q;
  assign out_valid    = (state_q == DONE);
  assign start_drop   = drop_q;
  assign timeout      = timeout_q;
  assign timeout_mask = mask_q;
  assign working      = working_q;
endmodule
